l2_snoop_responder: RTL and testbench

Southbound responder for the L1 cache's cache-snooper interface. Accepts one-cycle line-read requests and one-cycle eviction writes from a single L1. Returns the requested 128-bit line on `cacheline_update_valid` after a fixed, parameterised latency. Backed by an internal line-granular store, so the block serves as the L2/main-memory model that closes the miss-recovery loop.

---
 rtl/l2_snoop_responder.sv | 105 ++++++++++
 tb/tb_l2_snoop_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/l2_snoop_responder.sv
// l2_snoop_responder: L2/main-memory model behind the L1 cache snooper.
// Serves one line read at a time after a fixed latency and absorbs eviction
// writes into a direct-indexed line store in every state.
module l2_snoop_responder #(
   parameter int LATENCY    = 4,
   parameter int LINE_IDX_W = 10
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [31:0]  snooper_addr,
   input  logic         snooper_read_valid,
   input  logic         eviction_wren,
   input  logic [127:0] evictable_cacheline,
   input  logic         fill_stall,
   output logic [127:0] updated_cacheline,
   output logic         cacheline_update_valid,
   output logic         busy,
   output logic         proto_err
);

   typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;

   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [LINE_IDX_W-1:0] idx_q, idx_d;
   logic [127:0]          fill_q, fill_d;
   logic                  perr_q, perr_d;

   logic [127:0]          store_q [2**LINE_IDX_W];
   logic [LINE_IDX_W-1:0] req_idx;
   logic [127:0]          rd_data;
   logic                  unused_addr_bits;

   // Offset bits and tag bits are never looked at; aliasing tags share a line.
   assign req_idx          = snooper_addr[4 +: LINE_IDX_W];
   assign unused_addr_bits = ^{snooper_addr[31:4+LINE_IDX_W], snooper_addr[3:0]};

   // Store read at the pending index, forwarding an eviction to that index
   // landing in the same cycle so the capture never sees stale data.
   always_comb begin
      rd_data = store_q[idx_q];
      if (eviction_wren && (req_idx == idx_q)) rd_data = evictable_cacheline;
   end

   // Next-state logic: accept in IDLE, count down in WAIT, hold fill in RESPOND.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      fill_d  = fill_q;
      perr_d  = perr_q;
      case (state_q)
         IDLE: begin
            if (snooper_read_valid) begin
               idx_d   = req_idx;
               cnt_d   = 8'(LATENCY - 2);
               state_d = WAIT;
            end
         end
         WAIT: begin
            if (snooper_read_valid) perr_d = 1'b1;
            if (cnt_q == 8'd0) begin
               fill_d  = rd_data;
               state_d = RESPOND;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         RESPOND: begin
            // Fill data stays frozen here; later evictions only reach the store.
            if (snooper_read_valid) perr_d = 1'b1;
            if (!fill_stall) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control and fill registers; reset drops any pending read.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         idx_q   <= '0;
         fill_q  <= '0;
         perr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         fill_q  <= fill_d;
         perr_q  <= perr_d;
      end
   end

   // Line store: written on eviction in any state, deliberately not reset.
   always_ff @(posedge clk) begin
      if (eviction_wren) store_q[req_idx] <= evictable_cacheline;
   end

   assign updated_cacheline      = fill_q;
   assign cacheline_update_valid = (state_q == RESPOND) && !fill_stall;
   assign busy                   = (state_q != IDLE);
   assign proto_err              = perr_q;

endmodule

// File: tb/tb_l2_snoop_responder.sv
// Scoreboard bench for l2_snoop_responder: stimulus pushes expected fills
// (cycle + data), a negedge monitor pops and compares on every strobe.
module tb_l2_snoop_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic [31:0] a_addr, b_addr;
   logic a_rd, a_ev, a_stall, b_rd, b_ev, b_stall;
   logic [127:0] a_evd, b_evd, a_fill, b_fill;
   logic a_valid, a_busy, a_perr, b_valid, b_busy, b_perr;

   l2_snoop_responder #(.LATENCY(4), .LINE_IDX_W(10)) dut_a (
      .clk(clk), .reset(reset), .snooper_addr(a_addr), .snooper_read_valid(a_rd),
      .eviction_wren(a_ev), .evictable_cacheline(a_evd), .fill_stall(a_stall),
      .updated_cacheline(a_fill), .cacheline_update_valid(a_valid),
      .busy(a_busy), .proto_err(a_perr));

   l2_snoop_responder #(.LATENCY(2), .LINE_IDX_W(10)) dut_b (
      .clk(clk), .reset(reset), .snooper_addr(b_addr), .snooper_read_valid(b_rd),
      .eviction_wren(b_ev), .evictable_cacheline(b_evd), .fill_stall(b_stall),
      .updated_cacheline(b_fill), .cacheline_update_valid(b_valid),
      .busy(b_busy), .proto_err(b_perr));

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int unsigned cyc; logic [127:0] data;} exp_t;
   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int n_cmp = 0;
   int n_bad = 0;

   localparam logic [127:0] D1 = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
   localparam logic [127:0] D2 = 128'h22222222_11111111_0F0F0F0F_F0F0F0F0;
   localparam logic [127:0] D3 = 128'h33333333_44444444_55555555_66666666;
   localparam logic [127:0] D4 = 128'hCAFEF00D_DEADBEEF_01234567_89ABCDEF;
   localparam logic [127:0] D5 = 128'h55555555_AAAAAAAA_55555555_AAAAAAAA;
   localparam logic [127:0] D6 = 128'h66666666_77777777_88888888_99999999;
   localparam logic [127:0] D7 = 128'h7777_0000_7777_0000_1234_5678_9ABC_DEF0;
   localparam logic [127:0] D8 = 128'h88888888_88888888_88888888_88888888;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   // Monitor: every strobe must match the oldest expected fill, in data and cycle.
   always @(negedge clk) begin
      if (a_valid === 1'b1) begin
         if (qa.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL a_unexpected_strobe cyc=%0d got=1 want=0", cyc);
         end else begin
            ea = qa.pop_front();
            chk("a_fill_data", a_fill, ea.data);
            chk("a_fill_cycle", 128'(cyc), 128'(ea.cyc));
         end
      end
      if (b_valid === 1'b1) begin
         if (qb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL b_unexpected_strobe cyc=%0d got=1 want=0", cyc);
         end else begin
            eb = qb.pop_front();
            chk("b_fill_data", b_fill, eb.data);
            chk("b_fill_cycle", 128'(cyc), 128'(eb.cyc));
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic a_cyc(input logic rd, input logic ev, input logic [31:0] addr,
                        input logic [127:0] d);
      a_rd = rd; a_ev = ev; a_addr = addr; a_evd = d;
      tick();
      a_rd = 1'b0; a_ev = 1'b0;
   endtask

   task automatic a_exp(input int unsigned c, input logic [127:0] d);
      qa.push_back('{cyc: c, data: d});
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned t;
      reset = 1'b1;
      a_rd = 0; a_ev = 0; a_stall = 0; a_addr = 0; a_evd = 0;
      b_rd = 0; b_ev = 0; b_stall = 0; b_addr = 0; b_evd = 0;
      idle(3);
      reset = 1'b0;
      @(negedge clk);
      chk("rst_a_valid", 128'(a_valid), 0);
      chk("rst_a_busy", 128'(a_busy), 0);
      chk("rst_a_perr", 128'(a_perr), 0);
      chk("rst_a_fill", a_fill, 0);
      chk("rst_b_valid", 128'(b_valid), 0);
      chk("rst_b_fill", b_fill, 0);
      tick();

      // Write then read; busy must cover T+1..T+4 only.
      a_cyc(0, 1, 32'h0000_0120, D1);
      idle(4);
      t = cyc; a_exp(t + 4, D1);
      a_cyc(1, 0, 32'h0000_0120, 0);
      repeat (4) begin
         @(negedge clk); chk("busy_high", 128'(a_busy), 1);
         tick();
      end
      @(negedge clk); chk("busy_low_after", 128'(a_busy), 0);
      tick();
      idle(2);

      // Miss with eviction to an aliasing address at T+1.
      t = cyc; a_exp(t + 4, D2);
      a_cyc(1, 0, 32'h0000_4120, 0);
      a_cyc(0, 1, 32'h0000_0120, D2);
      idle(6);

      // Stall over T+4..T+6: strobe moves to T+7, data held throughout.
      t = cyc; a_exp(t + 7, D2);
      a_cyc(1, 0, 32'h0000_0120, 0);
      idle(3);
      a_stall = 1'b1;
      repeat (3) begin
         @(negedge clk); chk("stall_data_hold", a_fill, D2);
         chk("stall_no_strobe", 128'(a_valid), 0);
         tick();
      end
      a_stall = 1'b0;
      @(negedge clk); chk("stall_data_release", a_fill, D2);
      tick();
      idle(3);

      // Read while busy sets the sticky error; the one fill still arrives.
      a_cyc(0, 1, 32'h0000_0200, D3);
      idle(1);
      t = cyc; a_exp(t + 4, D3);
      a_cyc(1, 0, 32'h0000_0200, 0);
      @(negedge clk); chk("perr_clear_before", 128'(a_perr), 0);
      tick();
      a_cyc(1, 0, 32'h0000_0380, 0);
      repeat (5) begin
         @(negedge clk); chk("perr_sticky", 128'(a_perr), 1);
         tick();
      end
      idle(2);

      // Reset mid-WAIT: outputs cleared, no fill, store contents survive.
      a_cyc(0, 1, 32'h0000_0300, D4);
      idle(1);
      a_cyc(1, 0, 32'h0000_0300, 0);
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_valid", 128'(a_valid), 0);
      chk("midrst_busy", 128'(a_busy), 0);
      chk("midrst_perr", 128'(a_perr), 0);
      chk("midrst_fill", a_fill, 0);
      tick();
      idle(8);
      t = cyc; a_exp(t + 4, D4);
      a_cyc(1, 0, 32'h0000_0300, 0);
      idle(6);

      // Read+evict same IDLE cycle, then evict during a stalled RESPOND.
      t = cyc; a_exp(t + 5, D5);
      a_cyc(1, 1, 32'h0000_0500, D5);
      idle(3);
      a_stall = 1'b1;
      a_cyc(0, 1, 32'h0000_0500, D6);
      a_stall = 1'b0;
      idle(3);
      t = cyc; a_exp(t + 4, D6);
      a_cyc(1, 0, 32'h0000_0500, 0);
      idle(6);

      // LATENCY=2: strobe at T+2 carries the T+1 eviction via bypass.
      b_ev = 1; b_addr = 32'h0000_0700; b_evd = D8;
      tick();
      b_ev = 0;
      tick();
      t = cyc; qb.push_back('{cyc: t + 2, data: D7});
      b_rd = 1; b_addr = 32'h0000_0700;
      tick();
      b_rd = 0; b_ev = 1; b_evd = D7;
      @(negedge clk); chk("b_busy_t1", 128'(b_busy), 1);
      tick();
      b_ev = 0;
      @(negedge clk); chk("b_busy_t2", 128'(b_busy), 1);
      tick();
      @(negedge clk); chk("b_busy_t3", 128'(b_busy), 0);
      tick();
      idle(4);

      chk("qa_drained", 128'(qa.size()), 0);
      chk("qb_drained", 128'(qb.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
